boot_stream_loader: RTL and testbench

- Hardware successor to the JTAG/debug-driven boot sequence.
- Consumes a 32-bit word stream from a boot source (SPI slave, UART or Ethernet RX FIFO) carrying one or more memory sections.
- Writes each section to memory as AXI4-style write bursts, writes the boot PC to the debug NPC register, then releases the CPU.
- Sits between the boot-source FIFO and one AXI master port of the SoC interconnect.

---
 rtl/boot_stream_loader_pkg.sv | 33 +++
 rtl/boot_stream_loader_burst_calc.sv | 27 ++
 rtl/boot_stream_loader.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_boot_stream_loader.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_stream_loader_pkg.sv
// boot_loader_pkg: shared state encoding, failure codes and the AXI 4 KB page
// constant for the boot stream loader. The CHK state only exists when the
// BOOT_LOADER_CRC_EN macro is defined.
package boot_loader_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_STALL,
      S_HDR_ADDR,
      S_HDR_LEN,
      S_AW,
      S_WDATA,
      S_BRESP,
`ifdef BOOT_LOADER_CRC_EN
      S_CHK,
`endif
      S_PC_AW,
      S_PC_W,
      S_PC_B,
      S_RESUME,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_ALIGN    = 3'd1;
   localparam logic [2:0] ERR_BUS      = 3'd2;
   localparam logic [2:0] ERR_OVERFLOW = 3'd3;
   localparam logic [2:0] ERR_CRC      = 3'd4;

   localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/boot_stream_loader_burst_calc.sv
// boot_burst_calc: picks the beat count of the next burst so that it never
// exceeds the words still owed, the burst length limit, or the 4 KB page end.
module boot_burst_calc
   import boot_loader_pkg::*;
#(
   parameter int BURST_MAX = 255
) (
   input  logic [9:0]  word_offset,
   input  logic [31:0] remaining,
   output logic [8:0]  beats
);

   logic [10:0] words_to_boundary;

   // Smallest of the three limits; word_offset is the word index inside the page
   always_comb begin
      words_to_boundary = 11'(BOUNDARY_4K / 4) - {1'b0, word_offset};
      beats = 9'(BURST_MAX);
      if (remaining < 32'(BURST_MAX)) begin
         beats = remaining[8:0];
      end
      if (words_to_boundary < {2'b00, beats}) begin
         beats = words_to_boundary[8:0];
      end
   end

endmodule

// File: rtl/boot_stream_loader.sv
// boot_stream_loader: halts the CPU, copies sections from a word stream into
// memory as AXI write bursts, writes the boot PC to the debug NPC register and
// releases the CPU. Define BOOT_LOADER_CRC_EN to require a per-section XOR
// trailer word that is checked before the section counts as complete.
module boot_stream_loader
   import boot_loader_pkg::*;
#(
   parameter int          ADDR_W       = 32,
   parameter int          BURST_MAX    = 255,
   parameter logic [31:0] NPC_ADDR     = 32'h1A11_2000,
   parameter int          MAX_SECTIONS = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_i,
   input  logic [31:0]                       s_data_i,
   input  logic                              s_valid_i,
   output logic                              s_ready_o,
   output logic                              cpu_stall_o,
   input  logic                              cpu_stalled_i,
   output logic [ADDR_W-1:0]                 aw_addr_o,
   output logic [7:0]                        aw_len_o,
   output logic                              aw_valid_o,
   input  logic                              aw_ready_i,
   output logic [31:0]                       w_data_o,
   output logic                              w_last_o,
   output logic                              w_valid_o,
   input  logic                              w_ready_i,
   input  logic [1:0]                        b_resp_i,
   input  logic                              b_valid_i,
   output logic                              b_ready_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              error_o,
   output logic [2:0]                        err_code_o,
   output logic [$clog2(MAX_SECTIONS+1)-1:0] sections_o
);

   localparam int SEC_W = $clog2(MAX_SECTIONS + 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       remaining_q;
   logic [31:0]       pc_q;
   logic [8:0]        beats_q;
   logic [8:0]        beat_cnt_q;
   logic [8:0]        beats_calc;
   logic [2:0]        err_code_q, err_d;
   logic [SEC_W-1:0]  sections_q;
   logic              section_end;
   logic              start_accept;
`ifdef BOOT_LOADER_CRC_EN
   logic [31:0]       crc_q;
`endif

   boot_burst_calc #(
      .BURST_MAX(BURST_MAX)
   ) u_burst_calc (
      .word_offset(addr_q[11:2]),
      .remaining  (remaining_q),
      .beats      (beats_calc)
   );

   assign err_code_o = err_code_q;
   assign sections_o = sections_q;

   // State register; reset abandons any burst in flight and returns to IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and all handshake outputs, which depend on state only
   // except for the pass-through W channel during WDATA
   always_comb begin
      state_d      = state_q;
      err_d        = ERR_NONE;
      section_end  = 1'b0;
      start_accept = 1'b0;
      s_ready_o    = 1'b0;
      cpu_stall_o  = 1'b0;
      aw_addr_o    = '0;
      aw_len_o     = 8'd0;
      aw_valid_o   = 1'b0;
      w_data_o     = 32'd0;
      w_last_o     = 1'b0;
      w_valid_o    = 1'b0;
      b_ready_o    = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      error_o      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               start_accept = 1'b1;
               state_d      = S_STALL;
            end
         end
         S_STALL: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            if (cpu_stalled_i) state_d = S_HDR_ADDR;
         end
         S_HDR_ADDR: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            s_ready_o   = 1'b1;
            if (s_valid_i) begin
               if (s_data_i[1:0] != 2'b00) begin
                  state_d = S_ERR;
                  err_d   = ERR_ALIGN;
               end else begin
                  state_d = S_HDR_LEN;
               end
            end
         end
         S_HDR_LEN: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            s_ready_o   = 1'b1;
            if (s_valid_i) begin
               state_d = (s_data_i == 32'd0) ? S_PC_AW : S_AW;
            end
         end
         S_AW: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            aw_addr_o   = addr_q;
            aw_len_o    = 8'(beats_calc - 9'd1);
            aw_valid_o  = 1'b1;
            if (aw_ready_i) state_d = S_WDATA;
         end
         S_WDATA: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            w_data_o    = s_data_i;
            w_valid_o   = s_valid_i;
            s_ready_o   = w_ready_i;
            w_last_o    = (beat_cnt_q == beats_q - 9'd1);
            if (s_valid_i && w_ready_i && w_last_o) state_d = S_BRESP;
         end
         S_BRESP: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            b_ready_o   = 1'b1;
            if (b_valid_i) begin
               if (b_resp_i != 2'b00) begin
                  state_d = S_ERR;
                  err_d   = ERR_BUS;
               end else if (remaining_q != 32'(beats_q)) begin
                  state_d = S_AW;
               end else begin
`ifdef BOOT_LOADER_CRC_EN
                  state_d = S_CHK;
`else
                  section_end = 1'b1;
`endif
               end
            end
         end
`ifdef BOOT_LOADER_CRC_EN
         S_CHK: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            s_ready_o   = 1'b1;
            if (s_valid_i) begin
               if (s_data_i != crc_q) begin
                  state_d = S_ERR;
                  err_d   = ERR_CRC;
               end else begin
                  section_end = 1'b1;
               end
            end
         end
`endif
         S_PC_AW: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            aw_addr_o   = ADDR_W'(NPC_ADDR);
            aw_valid_o  = 1'b1;
            if (aw_ready_i) state_d = S_PC_W;
         end
         S_PC_W: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            w_data_o    = pc_q;
            w_last_o    = 1'b1;
            w_valid_o   = 1'b1;
            if (w_ready_i) state_d = S_PC_B;
         end
         S_PC_B: begin
            busy_o      = 1'b1;
            cpu_stall_o = 1'b1;
            b_ready_o   = 1'b1;
            if (b_valid_i) begin
               if (b_resp_i != 2'b00) begin
                  state_d = S_ERR;
                  err_d   = ERR_BUS;
               end else begin
                  state_d = S_RESUME;
               end
            end
         end
         S_RESUME: begin
            busy_o  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            done_o = 1'b1;
            if (start_i) begin
               start_accept = 1'b1;
               state_d      = S_STALL;
            end
         end
         S_ERR: begin
            error_o     = 1'b1;
            cpu_stall_o = 1'b1;
            if (start_i) begin
               start_accept = 1'b1;
               state_d      = S_STALL;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (section_end) begin
         if (sections_q == SEC_W'(MAX_SECTIONS - 1)) begin
            state_d = S_ERR;
            err_d   = ERR_OVERFLOW;
         end else begin
            state_d = S_HDR_ADDR;
         end
      end
   end

   // Section bookkeeping: header capture, burst progress, counters and the
   // failure code that is latched on the way into ERR
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         remaining_q <= 32'd0;
         pc_q        <= 32'd0;
         beats_q     <= 9'd0;
         beat_cnt_q  <= 9'd0;
         err_code_q  <= ERR_NONE;
         sections_q  <= '0;
`ifdef BOOT_LOADER_CRC_EN
         crc_q       <= 32'd0;
`endif
      end else begin
         if (start_accept) begin
            err_code_q <= ERR_NONE;
            sections_q <= '0;
         end
         if (state_d == S_ERR && state_q != S_ERR) begin
            err_code_q <= err_d;
         end
         if (section_end) begin
            sections_q <= sections_q + 1'b1;
         end
         case (state_q)
            S_HDR_ADDR: begin
               if (s_valid_i) begin
                  addr_q <= ADDR_W'(s_data_i);
                  pc_q   <= s_data_i;
`ifdef BOOT_LOADER_CRC_EN
                  crc_q  <= s_data_i;
`endif
               end
            end
            S_HDR_LEN: begin
               if (s_valid_i) begin
                  remaining_q <= s_data_i;
`ifdef BOOT_LOADER_CRC_EN
                  crc_q       <= crc_q ^ s_data_i;
`endif
               end
            end
            S_AW: begin
               if (aw_ready_i) begin
                  beats_q    <= beats_calc;
                  beat_cnt_q <= 9'd0;
               end
            end
            S_WDATA: begin
               if (s_valid_i && w_ready_i) begin
                  beat_cnt_q <= beat_cnt_q + 9'd1;
`ifdef BOOT_LOADER_CRC_EN
                  crc_q      <= crc_q ^ s_data_i;
`endif
               end
            end
            S_BRESP: begin
               if (b_valid_i && b_resp_i == 2'b00) begin
                  addr_q      <= addr_q + ADDR_W'({beats_q, 2'b00});
                  remaining_q <= remaining_q - 32'(beats_q);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_stream_loader.sv
// tb_boot_stream_loader: directed boot images against a stream/AXI responder.
// A model derives the expected AW and W traffic from the image words; a single
// negedge process compares every handshake against it. Define
// BOOT_LOADER_CRC_EN to add trailer words and the checksum cases.
`timescale 1ns/1ps
module tb_boot_stream_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [31:0] s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic        cpu_stall_o;
   logic        cpu_stalled_i;
   logic [31:0] aw_addr_o;
   logic [7:0]  aw_len_o;
   logic        aw_valid_o;
   logic        aw_ready_i;
   logic [31:0] w_data_o;
   logic        w_last_o;
   logic        w_valid_o;
   logic        w_ready_i;
   logic [1:0]  b_resp_i;
   logic        b_valid_i;
   logic        b_ready_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic [2:0]  err_code_o;
   logic [3:0]  sections_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] stream[$];
   logic [31:0] exp_aw_addr[$];
   logic [31:0] exp_aw_len[$];
   logic [31:0] exp_w_data[$];
   logic [31:0] exp_w_last[$];
   logic [31:0] obs_aw_addr[$];
   logic [31:0] obs_aw_len[$];
   logic [31:0] obs_w_data[$];

   bit gap_en      = 1'b0;
   bit corrupt_crc = 1'b0;
   int bad_burst   = -1;
   int burst_idx   = 0;
   bit s_fire, aw_fire, w_fire, b_fire, w_last_s;
   bit prev_stall  = 1'b0;
   int cycle       = 0;
   int last_b_cycle = 0;
   int fall_cycle   = 0;

   boot_stream_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .s_data_i     (s_data_i),
      .s_valid_i    (s_valid_i),
      .s_ready_o    (s_ready_o),
      .cpu_stall_o  (cpu_stall_o),
      .cpu_stalled_i(cpu_stalled_i),
      .aw_addr_o    (aw_addr_o),
      .aw_len_o     (aw_len_o),
      .aw_valid_o   (aw_valid_o),
      .aw_ready_i   (aw_ready_i),
      .w_data_o     (w_data_o),
      .w_last_o     (w_last_o),
      .w_valid_o    (w_valid_o),
      .w_ready_i    (w_ready_i),
      .b_resp_i     (b_resp_i),
      .b_valid_i    (b_valid_i),
      .b_ready_o    (b_ready_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .err_code_o   (err_code_o),
      .sections_o   (sections_o)
   );

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic clearImage();
      stream.delete();
      exp_aw_addr.delete();
      exp_aw_len.delete();
      exp_w_data.delete();
      exp_w_last.delete();
      obs_aw_addr.delete();
      obs_aw_len.delete();
      obs_w_data.delete();
   endtask

   task automatic loadSection(input logic [31:0] addr, input logic [31:0] count, input logic [31:0] base);
      logic [31:0] x;
      x = addr ^ count;
      stream.push_back(addr);
      stream.push_back(count);
      for (int j = 0; j < int'(count); j++) begin
         stream.push_back(base + 32'(j));
         x = x ^ (base + 32'(j));
      end
`ifdef BOOT_LOADER_CRC_EN
      stream.push_back(corrupt_crc ? (x ^ 32'd1) : x);
`endif
   endtask

   task automatic loadTerm(input logic [31:0] pc);
      stream.push_back(pc);
      stream.push_back(32'd0);
   endtask

   // Expected traffic: split each section at 255 beats and at 4 KB pages
   task automatic buildModel();
      int i;
      int secs;
      logic [31:0] a, rem, b, room;
      i = 0;
      secs = 0;
      while (i + 1 < stream.size()) begin
         a = stream[i];
         rem = stream[i + 1];
         i += 2;
         if (rem == 32'd0) begin
            exp_aw_addr.push_back(32'h1A11_2000);
            exp_aw_len.push_back(32'd0);
            exp_w_data.push_back(a);
            exp_w_last.push_back(32'd1);
            break;
         end
         while (rem != 32'd0 && i < stream.size()) begin
            room = (32'd4096 - (a % 32'd4096)) / 32'd4;
            b = rem;
            if (b > 32'd255) b = 32'd255;
            if (b > room) b = room;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(b - 32'd1);
            for (int k = 0; k < int'(b); k++) begin
               exp_w_data.push_back(stream[i]);
               exp_w_last.push_back((k == int'(b) - 1) ? 32'd1 : 32'd0);
               i++;
            end
            a = a + 32'd4 * b;
            rem = rem - b;
         end
`ifdef BOOT_LOADER_CRC_EN
         i++;
`endif
         secs++;
         if (secs == 8) break;
      end
   endtask

   task automatic applyStimulus();
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic waitEnd();
      int n;
      n = 0;
      while (!(done_o || error_o) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("finished", 32'(done_o | error_o), 32'd1);
   endtask

   task automatic checkEnd(input logic want_done, input logic [2:0] want_code, input int want_secs);
      checkOutput("done", 32'(done_o), 32'(want_done));
      checkOutput("error", 32'(error_o), 32'(!want_done));
      checkOutput("err_code", 32'(err_code_o), 32'(want_code));
      checkOutput("sections", 32'(sections_o), 32'(want_secs));
      checkOutput("cpu_stall", 32'(cpu_stall_o), 32'(!want_done));
      checkOutput("busy_end", 32'(busy_o), 32'd0);
      if (want_done) begin
         checkOutput("aw_left", 32'(exp_aw_addr.size()), 32'd0);
         checkOutput("w_left", 32'(exp_w_data.size()), 32'd0);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_s_ready"}, 32'(s_ready_o), 32'd0);
      checkOutput({tag, "_stall"}, 32'(cpu_stall_o), 32'd0);
      checkOutput({tag, "_aw_addr"}, aw_addr_o, 32'd0);
      checkOutput({tag, "_aw_len"}, 32'(aw_len_o), 32'd0);
      checkOutput({tag, "_aw_valid"}, 32'(aw_valid_o), 32'd0);
      checkOutput({tag, "_w_data"}, w_data_o, 32'd0);
      checkOutput({tag, "_w_last"}, 32'(w_last_o), 32'd0);
      checkOutput({tag, "_w_valid"}, 32'(w_valid_o), 32'd0);
      checkOutput({tag, "_b_ready"}, 32'(b_ready_o), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
      checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
      checkOutput({tag, "_error"}, 32'(error_o), 32'd0);
      checkOutput({tag, "_err_code"}, 32'(err_code_o), 32'd0);
      checkOutput({tag, "_sections"}, 32'(sections_o), 32'd0);
   endtask

   task automatic resetDut();
      rst = 1'b1;
      clearImage();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Compare process: every handshake is checked against the model queues
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         s_fire   = s_valid_i && s_ready_o;
         aw_fire  = aw_valid_o && aw_ready_i;
         w_fire   = w_valid_o && w_ready_i;
         b_fire   = b_valid_i && b_ready_o;
         w_last_s = w_last_o;
         if (!rst) begin
            if (aw_valid_o || w_valid_o) begin
               checkOutput("aw_w_exclusive", 32'(aw_valid_o && w_valid_o), 32'd0);
            end
            if (aw_fire) begin
               obs_aw_addr.push_back(aw_addr_o);
               obs_aw_len.push_back(32'(aw_len_o));
               checkOutput("aw_addr", aw_addr_o, (exp_aw_addr.size() > 0) ? exp_aw_addr.pop_front() : 32'hxxxx_xxxx);
               checkOutput("aw_len", 32'(aw_len_o), (exp_aw_len.size() > 0) ? exp_aw_len.pop_front() : 32'hxxxx_xxxx);
            end
            if (w_fire) begin
               obs_w_data.push_back(w_data_o);
               checkOutput("w_data", w_data_o, (exp_w_data.size() > 0) ? exp_w_data.pop_front() : 32'hxxxx_xxxx);
               checkOutput("w_last", 32'(w_last_o), (exp_w_last.size() > 0) ? exp_w_last.pop_front() : 32'hxxxx_xxxx);
            end
            if (b_fire) last_b_cycle = cycle;
            if (prev_stall && !cpu_stall_o) fall_cycle = cycle;
         end
         prev_stall = cpu_stall_o;
      end
   end

   // Stream source and AXI slave responder, updated just after each edge
   initial begin
      s_valid_i  = 1'b0;
      s_data_i   = 32'd0;
      aw_ready_i = 1'b0;
      w_ready_i  = 1'b0;
      b_valid_i  = 1'b0;
      b_resp_i   = 2'b00;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            b_valid_i = 1'b0;
            b_resp_i  = 2'b00;
            burst_idx = 0;
         end else begin
            if (s_fire && stream.size() > 0) void'(stream.pop_front());
            if (b_fire) begin
               b_valid_i = 1'b0;
               b_resp_i  = 2'b00;
            end
            if (w_fire && w_last_s) begin
               b_valid_i = 1'b1;
               b_resp_i  = (burst_idx == bad_burst) ? 2'b10 : 2'b00;
               burst_idx++;
            end
         end
         s_valid_i  = (stream.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
         s_data_i   = (stream.size() > 0) ? stream[0] : 32'd0;
         w_ready_i  = !gap_en || ($urandom_range(0, 2) != 0);
         aw_ready_i = !gap_en || ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      start_i = 1'b0;
      cpu_stalled_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] single section with terminator");
      clearImage();
      loadSection(32'h0, 32'd3, 32'hA);
      loadTerm(32'h80);
      buildModel();
      cpu_stalled_i = 1'b0;
      applyStimulus();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall_wait_stall", 32'(cpu_stall_o), 32'd1);
      checkOutput("stall_wait_ready", 32'(s_ready_o), 32'd0);
      checkOutput("stall_wait_busy", 32'(busy_o), 32'd1);
      cpu_stalled_i = 1'b1;
      waitEnd();
      checkOutput("single_aw_addr", obs_aw_addr[0], 32'h0);
      checkOutput("single_aw_len", obs_aw_len[0], 32'd2);
      checkOutput("single_w_c", obs_w_data[2], 32'hC);
      checkOutput("npc_addr", obs_aw_addr[obs_aw_addr.size() - 1], 32'h1A11_2000);
      checkOutput("npc_data", obs_w_data[obs_w_data.size() - 1], 32'h80);
      checkOutput("stall_fall_delay", 32'(fall_cycle - last_b_cycle), 32'd1);
      checkEnd(1'b1, 3'd0, 1);

      $display("[TB] splitting at burst limit");
      clearImage();
      loadSection(32'h0010_0000, 32'd600, 32'h1000);
      loadTerm(32'h0010_0000);
      buildModel();
      applyStimulus();
      waitEnd();
      checkOutput("split_a0", obs_aw_addr[0], 32'h0010_0000);
      checkOutput("split_a1", obs_aw_addr[1], 32'h0010_03FC);
      checkOutput("split_a2", obs_aw_addr[2], 32'h0010_07F8);
      checkOutput("split_l0", obs_aw_len[0], 32'd254);
      checkOutput("split_l1", obs_aw_len[1], 32'd254);
      checkOutput("split_l2", obs_aw_len[2], 32'd89);
      checkEnd(1'b1, 3'd0, 1);

      $display("[TB] 4 KB boundary");
      clearImage();
      loadSection(32'h0000_0FF8, 32'd4, 32'h55);
      loadTerm(32'h100);
      buildModel();
      applyStimulus();
      waitEnd();
      checkOutput("page_a0", obs_aw_addr[0], 32'h0000_0FF8);
      checkOutput("page_l0", obs_aw_len[0], 32'd1);
      checkOutput("page_a1", obs_aw_addr[1], 32'h0000_1000);
      checkOutput("page_l1", obs_aw_len[1], 32'd1);
      checkEnd(1'b1, 3'd0, 1);

      $display("[TB] backpressure on stream and W channel");
      clearImage();
      gap_en = 1'b1;
      loadSection(32'h2000, 32'd20, 32'h100);
      loadSection(32'h3000, 32'd5, 32'h200);
      loadTerm(32'h2000);
      buildModel();
      applyStimulus();
      waitEnd();
      checkEnd(1'b1, 3'd0, 2);
      gap_en = 1'b0;

      $display("[TB] misaligned section address");
      clearImage();
      loadSection(32'h2, 32'd2, 32'h7);
      buildModel();
      applyStimulus();
      waitEnd();
      checkOutput("align_no_aw", 32'(obs_aw_addr.size()), 32'd0);
      checkEnd(1'b0, 3'd1, 0);

      $display("[TB] bus error on second burst");
      resetDut();
      bad_burst = 1;
      loadSection(32'h4000, 32'd300, 32'h300);
      loadTerm(32'h4000);
      buildModel();
      applyStimulus();
      waitEnd();
      checkOutput("bus_err_bursts", 32'(obs_aw_addr.size()), 32'd2);
      checkEnd(1'b0, 3'd2, 0);
      bad_burst = -1;

      $display("[TB] restart from error");
      clearImage();
      loadSection(32'h8000, 32'd1, 32'h9);
      loadTerm(32'h8000);
      buildModel();
      applyStimulus();
      waitEnd();
      checkEnd(1'b1, 3'd0, 1);

      $display("[TB] section overflow");
      resetDut();
      for (int k = 0; k < 8; k++) begin
         loadSection(32'h100 * 32'(k), 32'd1, 32'(k));
      end
      loadTerm(32'h100);
      buildModel();
      applyStimulus();
      waitEnd();
      checkOutput("ovf_bursts", 32'(obs_aw_addr.size()), 32'd8);
      checkEnd(1'b0, 3'd3, 8);

      $display("[TB] reset in the middle of a burst");
      resetDut();
      loadSection(32'h5000, 32'd4, 32'h400);
      loadSection(32'h6000, 32'd50, 32'h500);
      loadTerm(32'h5000);
      buildModel();
      applyStimulus();
      n = 0;
      while (!(sections_o == 4'd1 && w_valid_o) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("mid_wdata_reached", 32'(w_valid_o), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      checkAllZero("midrst");
      rst = 1'b0;
      clearImage();
      @(posedge clk); #1;

`ifdef BOOT_LOADER_CRC_EN
      $display("[TB] checksum trailer accepted");
      resetDut();
      loadSection(32'h7000, 32'd6, 32'h600);
      loadTerm(32'h7000);
      buildModel();
      applyStimulus();
      waitEnd();
      checkEnd(1'b1, 3'd0, 1);

      $display("[TB] checksum trailer corrupted");
      clearImage();
      corrupt_crc = 1'b1;
      loadSection(32'h7000, 32'd6, 32'h600);
      loadTerm(32'h7000);
      corrupt_crc = 1'b0;
      buildModel();
      applyStimulus();
      waitEnd();
      checkEnd(1'b0, 3'd4, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
